bcd_updown_counter: RTL and testbench
=====================================

# bcd_updown_counter

- Parametrised multi-digit BCD counter: counts up or down, supports a programmable terminal value, and generates a wrap pulse.
- Optionally supports synchronous parallel load of a BCD value.
- Drives the seven-segment display path and any lab datapath that needs a decimal event count.
- Supersedes the fixed two-digit, up-only counter; digit count and modulus are build-time parameters.

## Interface

- DIGITS, 2, number of BCD digits (1..8); count width is 4*DIGITS bits.
- MAX_COUNT, 99, terminal value in decimal; must be ≤ 10^DIGITS − 1. Range is 0..MAX_COUNT.

- clk1  input  1  clock, rising-edge active
- rst1  input  1  asynchronous, active-low reset
- en  input  1  count enable; 1 = step this cycle, 0 = hold
- ud  input  1  direction; 1 = up, 0 = down
- load  input  1  synchronous parallel load (only with BCDCNT_LOAD_EN)
- din  input  4*DIGITS  BCD load value, digit 0 in bits [3:0] (only with BCDCNT_LOAD_EN)
- count  output  4*DIGITS  registered BCD count, digit 0 (units) in bits [3:0]
- tc  output  1  terminal-count indicator, combinational from count and ud
- wrap  output  1  registered one-cycle pulse after a wrap
- load_err  output  1  registered one-cycle pulse after a rejected load (only with BCDCNT_LOAD_EN)

## Operation

- **Reset (rst1 = 0):** immediately, independent of clk1, count = 0, wrap = 0, load_err = 0. Reset held overrides all inputs.
- **Priority per clk1 edge:** load (if compiled in) > en > hold.

- **Up step (en = 1, ud = 1):**
  - If count == MAX_COUNT, count → 0 and wrap = 1 next cycle.
  - Otherwise increment digit 0. A digit at 9 goes to 0 and carries into the next digit. Carries ripple within the same cycle.
- **Down step (en = 1, ud = 0):**
  - If count == 0, count → MAX_COUNT and wrap = 1 next cycle.
  - Otherwise decrement digit 0. A digit at 0 goes to 9 and borrows from the next digit.
- **Hold (en = 0):** count unchanged, wrap = 0.

- **tc:**
  - 1 when ud = 1 and count == MAX_COUNT.
  - 1 when ud = 0 and count == 0.
  - 0 otherwise. Does not depend on en.
- **Width and encoding rules:**
  - Every digit of count is always in 0..9.
  - MAX_COUNT is converted to a BCD constant at elaboration.
  - Compare and step logic operates on BCD digits only; there is no binary intermediate.

## Timing

- count, wrap and load_err update on the rising edge of clk1. Latency from en/ud/load sampling to count change is 1 cycle.
- wrap and load_err are high for exactly one cycle, the cycle following the edge that caused them. Under sustained wrapping (e.g. MAX_COUNT = 0 with en = 1) wrap stays high.
- tc is valid combinationally in the same cycle as count and follows ud changes with no clock delay.
- Direction change mid-count: the new ud takes effect on the next edge with no extra cycle. For example, count = 5, ud 1→0 with en = 1 gives 4.
- **Reset asserted mid-operation:** outputs clear asynchronously. On reset release the first edge with en = 1 steps from 0. An up step gives 1; a down step wraps to MAX_COUNT with wrap = 1.

## Configuration

- **BCDCNT_LOAD_EN defined:**
  - load and din ports exist.
  - On an edge with load = 1, din is accepted if every digit ≤ 9 and the value ≤ MAX_COUNT: count ← din, and wrap = 0 next cycle.
  - Otherwise count holds and load_err = 1 next cycle.
  - load overrides en on the same edge.
- **BCDCNT_LOAD_EN undefined:**
  - load, din and load_err ports are absent and there is no load logic.
  - The block is a pure counter.

## Test plan

- **Reset:** rst1 = 0 mid-count at count = 0x47 (DIGITS = 2) → count = 0x00 with no clock edge; wrap = 0.
- **Up wrap** (MAX_COUNT = 99): en = 1, ud = 1 for 100 edges from 0 → count passes 0x09→0x10 and 0x98→0x99 (tc = 1), then 0x00. wrap is high exactly the cycle after 0x99→0x00.
- **Down wrap with custom modulus** (DIGITS = 2, MAX_COUNT = 59): en = 1, ud = 0 from 0x00 → 0x59 with wrap pulse, then 0x58. tc is 1 only at 0x00.
- **Hold and direction change:** count = 0x30, en = 0 for 3 edges → stays 0x30. Then en = 1, ud = 0 → 0x29, then ud = 1 → 0x30.
- **Load** (BCDCNT_LOAD_EN, MAX_COUNT = 59):
  - load = 1, din = 0x42, en = 1 → count = 0x42.
  - din = 0x3A → count holds, load_err pulse.
  - din = 0x75 → count holds, load_err pulse.
- **Wide config** (DIGITS = 4, MAX_COUNT = 9999): count = 0x0999, up step → 0x1000 (three-digit ripple in one cycle).

Source files
------------

// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter: multi-digit BCD up/down counter with terminal value and wrap pulse.
// Define BCDCNT_LOAD_EN to add synchronous parallel load with range checking.
module bcd_updown_counter #(
    parameter int DIGITS    = 2,
    parameter int MAX_COUNT = 99
) (
    input  logic                clk1,
    input  logic                rst1,
    input  logic                en,
    input  logic                ud,
`ifdef BCDCNT_LOAD_EN
    input  logic                load,
    input  logic [4*DIGITS-1:0] din,
    output logic                load_err,
`endif
    output logic [4*DIGITS-1:0] count,
    output logic                tc,
    output logic                wrap
);

    localparam int W = 4 * DIGITS;

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int           rem;
        r   = '0;
        rem = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i+:4] = 4'(rem % 10);
            rem       = rem / 10;
        end
        return r;
    endfunction

    localparam logic [W-1:0] MAX_BCD = to_bcd(MAX_COUNT);

    logic [W-1:0] inc;
    logic [W-1:0] dec;
    logic [W-1:0] count_next;
    logic         wrap_next;
    logic         at_max;
    logic         at_zero;

    assign at_max  = (count == MAX_BCD);
    assign at_zero = (count == '0);
    assign tc      = ud ? at_max : at_zero;

    // Per-digit ripple: carry/borrow propagates through all digits in one cycle
    always_comb begin : step_up
        logic carry;
        carry = 1'b1;
        inc   = count;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (count[4*i+:4] == 4'd9) begin
                    inc[4*i+:4] = 4'd0;
                end else begin
                    inc[4*i+:4] = count[4*i+:4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
    end

    always_comb begin : step_down
        logic borrow;
        borrow = 1'b1;
        dec    = count;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (count[4*i+:4] == 4'd0) begin
                    dec[4*i+:4] = 4'd9;
                end else begin
                    dec[4*i+:4] = count[4*i+:4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
    end

`ifdef BCDCNT_LOAD_EN
    logic din_ok;
    logic err_next;

    // Valid BCD digits compare in the same order as their decimal values
    always_comb begin : load_check
        din_ok = (din <= MAX_BCD);
        for (int i = 0; i < DIGITS; i++) begin
            if (din[4*i+:4] > 4'd9) din_ok = 1'b0;
        end
    end
`endif

    always_comb begin : next_state
        count_next = count;
        wrap_next  = 1'b0;
        if (en) begin
            if (ud) begin
                count_next = at_max ? '0 : inc;
                wrap_next  = at_max;
            end else begin
                count_next = at_zero ? MAX_BCD : dec;
                wrap_next  = at_zero;
            end
        end
`ifdef BCDCNT_LOAD_EN
        err_next = 1'b0;
        if (load) begin
            wrap_next  = 1'b0;
            count_next = din_ok ? din : count;
            err_next   = ~din_ok;
        end
`endif
    end

    always_ff @(posedge clk1 or negedge rst1) begin
        if (!rst1) begin
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            count <= count_next;
            wrap  <= wrap_next;
        end
    end

`ifdef BCDCNT_LOAD_EN
    always_ff @(posedge clk1 or negedge rst1) begin
        if (!rst1) load_err <= 1'b0;
        else       load_err <= err_next;
    end
`endif

endmodule

// File: tb/tb_bcd_updown_counter.sv
// tb_bcd_updown_counter: directed checks of the BCD counter in three configurations.
// Load checks are compiled only when BCDCNT_LOAD_EN is defined.
module tb_bcd_updown_counter;

    logic        clk1;
    logic        rst1;
    logic        en_a, ud_a, en_b, ud_b, en_c, ud_c;
    logic [7:0]  count_a, count_b;
    logic [15:0] count_c;
    logic        tc_a, tc_b, tc_c, wrap_a, wrap_b, wrap_c;
`ifdef BCDCNT_LOAD_EN
    logic        load_a, load_b, load_c;
    logic [7:0]  din_a, din_b;
    logic [15:0] din_c;
    logic        err_a, err_b, err_c;
`endif

    int checks = 0;
    int errors = 0;

    bcd_updown_counter #(.DIGITS(2), .MAX_COUNT(99)) u_dut (
        .clk1(clk1), .rst1(rst1), .en(en_a), .ud(ud_a),
`ifdef BCDCNT_LOAD_EN
        .load(load_a), .din(din_a), .load_err(err_a),
`endif
        .count(count_a), .tc(tc_a), .wrap(wrap_a)
    );

    bcd_updown_counter #(.DIGITS(2), .MAX_COUNT(59)) u_dut59 (
        .clk1(clk1), .rst1(rst1), .en(en_b), .ud(ud_b),
`ifdef BCDCNT_LOAD_EN
        .load(load_b), .din(din_b), .load_err(err_b),
`endif
        .count(count_b), .tc(tc_b), .wrap(wrap_b)
    );

    bcd_updown_counter #(.DIGITS(4), .MAX_COUNT(9999)) u_dut4 (
        .clk1(clk1), .rst1(rst1), .en(en_c), .ud(ud_c),
`ifdef BCDCNT_LOAD_EN
        .load(load_c), .din(din_c), .load_err(err_c),
`endif
        .count(count_c), .tc(tc_c), .wrap(wrap_c)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic do_reset();
        rst1 = 1'b0;
        #2;
        rst1 = 1'b1;
    endtask

    task automatic test_reset();
        rst1 = 1'b0;
        #2;
        checks++;
        if (count_a !== 8'h00 || wrap_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_init: count=%h wrap=%b, want 00 0", count_a, wrap_a);
        end
        checks++;
        if (tc_a !== 1'b1) begin
            errors++;
            $display("FAIL reset_tc: tc=%b, want 1", tc_a);
        end
        #10;
        rst1 = 1'b1;
        en_a = 1'b1;
        ud_a = 1'b1;
        repeat (47) tick();
        checks++;
        if (count_a !== 8'h47) begin
            errors++;
            $display("FAIL reset_pre47: count=%h, want 47", count_a);
        end
        #1;
        rst1 = 1'b0;
        #1;
        checks++;
        if (count_a !== 8'h00 || wrap_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: count=%h wrap=%b, want 00 0", count_a, wrap_a);
        end
        #4;
        rst1 = 1'b1;
        ud_a = 1'b0;
        tick();
        checks++;
        if (count_a !== 8'h99 || wrap_a !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_down: count=%h wrap=%b, want 99 1", count_a, wrap_a);
        end
        en_a = 1'b0;
    endtask

    task automatic test_up_wrap();
        do_reset();
        en_a = 1'b1;
        ud_a = 1'b1;
        repeat (9) tick();
        checks++;
        if (count_a !== 8'h09) begin
            errors++;
            $display("FAIL up_09: count=%h, want 09", count_a);
        end
        tick();
        checks++;
        if (count_a !== 8'h10) begin
            errors++;
            $display("FAIL up_10: count=%h, want 10", count_a);
        end
        repeat (88) tick();
        checks++;
        if (count_a !== 8'h98 || tc_a !== 1'b0) begin
            errors++;
            $display("FAIL up_98: count=%h tc=%b, want 98 0", count_a, tc_a);
        end
        tick();
        checks++;
        if (count_a !== 8'h99 || tc_a !== 1'b1 || wrap_a !== 1'b0) begin
            errors++;
            $display("FAIL up_99: count=%h tc=%b wrap=%b, want 99 1 0", count_a, tc_a, wrap_a);
        end
        tick();
        checks++;
        if (count_a !== 8'h00 || wrap_a !== 1'b1 || tc_a !== 1'b0) begin
            errors++;
            $display("FAIL up_wrap: count=%h wrap=%b tc=%b, want 00 1 0", count_a, wrap_a, tc_a);
        end
        en_a = 1'b0;
        tick();
        checks++;
        if (count_a !== 8'h00 || wrap_a !== 1'b0) begin
            errors++;
            $display("FAIL up_wrap_end: count=%h wrap=%b, want 00 0", count_a, wrap_a);
        end
    endtask

    task automatic test_hold_dir();
        en_a = 1'b1;
        ud_a = 1'b1;
        repeat (30) tick();
        en_a = 1'b0;
        repeat (3) tick();
        checks++;
        if (count_a !== 8'h30 || wrap_a !== 1'b0) begin
            errors++;
            $display("FAIL hold: count=%h wrap=%b, want 30 0", count_a, wrap_a);
        end
        en_a = 1'b1;
        ud_a = 1'b0;
        tick();
        checks++;
        if (count_a !== 8'h29) begin
            errors++;
            $display("FAIL dir_down: count=%h, want 29", count_a);
        end
        ud_a = 1'b1;
        tick();
        checks++;
        if (count_a !== 8'h30) begin
            errors++;
            $display("FAIL dir_up: count=%h, want 30", count_a);
        end
        en_a = 1'b0;
    endtask

    task automatic test_down_wrap();
        do_reset();
        en_b = 1'b0;
        ud_b = 1'b0;
        #1;
        checks++;
        if (tc_b !== 1'b1) begin
            errors++;
            $display("FAIL down_tc0: tc=%b, want 1", tc_b);
        end
        en_b = 1'b1;
        tick();
        checks++;
        if (count_b !== 8'h59 || wrap_b !== 1'b1 || tc_b !== 1'b0) begin
            errors++;
            $display("FAIL down_wrap: count=%h wrap=%b tc=%b, want 59 1 0", count_b, wrap_b, tc_b);
        end
        ud_b = 1'b1;
        #1;
        checks++;
        if (tc_b !== 1'b1) begin
            errors++;
            $display("FAIL tc_comb_ud: tc=%b, want 1", tc_b);
        end
        ud_b = 1'b0;
        tick();
        checks++;
        if (count_b !== 8'h58 || wrap_b !== 1'b0) begin
            errors++;
            $display("FAIL down_58: count=%h wrap=%b, want 58 0", count_b, wrap_b);
        end
        repeat (9) tick();
        checks++;
        if (count_b !== 8'h49 || tc_b !== 1'b0) begin
            errors++;
            $display("FAIL down_borrow: count=%h tc=%b, want 49 0", count_b, tc_b);
        end
        en_b = 1'b0;
    endtask

    task automatic test_wide();
        do_reset();
        en_c = 1'b1;
        ud_c = 1'b1;
        repeat (999) tick();
        checks++;
        if (count_c !== 16'h0999) begin
            errors++;
            $display("FAIL wide_0999: count=%h, want 0999", count_c);
        end
        tick();
        checks++;
        if (count_c !== 16'h1000 || wrap_c !== 1'b0) begin
            errors++;
            $display("FAIL wide_ripple: count=%h wrap=%b, want 1000 0", count_c, wrap_c);
        end
        do_reset();
        ud_c = 1'b0;
        tick();
        checks++;
        if (count_c !== 16'h9999 || wrap_c !== 1'b1) begin
            errors++;
            $display("FAIL wide_down_wrap: count=%h wrap=%b, want 9999 1", count_c, wrap_c);
        end
        ud_c = 1'b1;
        #1;
        checks++;
        if (tc_c !== 1'b1) begin
            errors++;
            $display("FAIL wide_tc: tc=%b, want 1", tc_c);
        end
        tick();
        checks++;
        if (count_c !== 16'h0000 || wrap_c !== 1'b1) begin
            errors++;
            $display("FAIL wide_up_wrap: count=%h wrap=%b, want 0000 1", count_c, wrap_c);
        end
        en_c = 1'b0;
    endtask

`ifdef BCDCNT_LOAD_EN
    task automatic test_load();
        do_reset();
        load_b = 1'b1;
        en_b   = 1'b1;
        ud_b   = 1'b1;
        din_b  = 8'h42;
        tick();
        checks++;
        if (count_b !== 8'h42 || err_b !== 1'b0 || wrap_b !== 1'b0) begin
            errors++;
            $display("FAIL load_42: count=%h err=%b wrap=%b, want 42 0 0", count_b, err_b, wrap_b);
        end
        din_b = 8'h3A;
        tick();
        checks++;
        if (count_b !== 8'h42 || err_b !== 1'b1) begin
            errors++;
            $display("FAIL load_3A: count=%h err=%b, want 42 1", count_b, err_b);
        end
        din_b = 8'h75;
        tick();
        checks++;
        if (count_b !== 8'h42 || err_b !== 1'b1) begin
            errors++;
            $display("FAIL load_75: count=%h err=%b, want 42 1", count_b, err_b);
        end
        din_b = 8'h59;
        tick();
        checks++;
        if (count_b !== 8'h59 || err_b !== 1'b0 || wrap_b !== 1'b0) begin
            errors++;
            $display("FAIL load_59: count=%h err=%b wrap=%b, want 59 0 0", count_b, err_b, wrap_b);
        end
        load_b = 1'b0;
        en_b   = 1'b0;
        tick();
        checks++;
        if (count_b !== 8'h59 || err_b !== 1'b0) begin
            errors++;
            $display("FAIL load_idle: count=%h err=%b, want 59 0", count_b, err_b);
        end
    endtask
`endif

    initial begin
        rst1 = 1'b0;
        en_a = 1'b0; ud_a = 1'b0;
        en_b = 1'b0; ud_b = 1'b0;
        en_c = 1'b0; ud_c = 1'b0;
`ifdef BCDCNT_LOAD_EN
        load_a = 1'b0; load_b = 1'b0; load_c = 1'b0;
        din_a  = '0;   din_b  = '0;   din_c  = '0;
`endif
        test_reset();
        test_up_wrap();
        test_hold_dir();
        test_down_wrap();
        test_wide();
`ifdef BCDCNT_LOAD_EN
        test_load();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
